// File: rtl/frame_buffer_arbiter_if.sv
// Signal bundle around frame_buffer_arbiter: display read port, pixel writer port,
// single-port BRAM port and double-buffer status.
interface frame_buffer_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 12
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_frame_done;
    logic              vsync_start;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              front_bank;
    logic              swap_pending;

    // Arbiter side.
    modport slave (
        input  disp_req, disp_addr,
        output disp_valid, disp_data,
        input  wr_valid, wr_addr, wr_data, wr_frame_done, vsync_start,
        output wr_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output front_bank, swap_pending
    );

    // Environment side: display, writer and BRAM.
    modport master (
        output disp_req, disp_addr,
        input  disp_valid, disp_data,
        output wr_valid, wr_addr, wr_data, wr_frame_done, vsync_start,
        input  wr_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  front_bank, swap_pending
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Single-port double-buffered frame-buffer arbiter: display reads always win, writer pixels
// queue in a small FIFO that drains into the back bank; banks swap only at vsync.
module frame_buffer_arbiter #(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    frame_buffer_arbiter_if.slave bus_io
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] StRun    = 1'b0;
    localparam logic [0:0] StWaitVs = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              front_bank_q, front_bank_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic              wr_ready_q, wr_ready_d;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic              rd_grant;
    logic              push;
    logic              pop;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W:0]   mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [MEM_LATENCY:0] rd_pipe_q;
    logic                 disp_valid_q;
    logic [DATA_W-1:0]    disp_data_q;

    always_comb begin
        rd_grant = bus_io.disp_req;
        pop      = !rd_grant && (count_q != '0);
        push     = bus_io.wr_valid && wr_ready_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);

        state_d      = state_q;
        front_bank_d = front_bank_q;
        case (state_q)
            StRun: begin
                if (bus_io.wr_frame_done) begin
                    state_d = StWaitVs;
                end
            end
            StWaitVs: begin
                // A vsync that finds pixels still queued is skipped; wait for the next one.
                if (bus_io.vsync_start && (count_q == '0)) begin
                    state_d      = StRun;
                    front_bank_d = ~front_bank_q;
                end
            end
            default: state_d = StRun;
        endcase

        wr_ready_d = (count_d < CntW'(FIFO_DEPTH)) && (state_d == StRun);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StRun;
            front_bank_q <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            count_q      <= count_d;
            wr_ready_q   <= wr_ready_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus_io.wr_addr;
            fifo_data_q[wr_ptr_q] <= bus_io.wr_data;
        end
    end

    // The bank bit of a write is taken at pop time, so a pop coinciding with a swap
    // still lands in the bank that was the back bank when it was granted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (rd_grant) begin
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {front_bank_q, bus_io.disp_addr};
        end else if (pop) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {~front_bank_q, fifo_addr_q[rd_ptr_q]};
            mem_wdata_q <= fifo_data_q[rd_ptr_q];
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end
    end

    // Bit k marks a read whose BRAM enable was visible k cycles ago.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_pipe_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            rd_pipe_q    <= {rd_pipe_q[MEM_LATENCY-1:0], rd_grant};
            disp_valid_q <= rd_pipe_q[MEM_LATENCY];
            if (rd_pipe_q[MEM_LATENCY]) begin
                disp_data_q <= bus_io.mem_rdata;
            end
        end
    end

    assign bus_io.mem_en       = mem_en_q;
    assign bus_io.mem_we       = mem_we_q;
    assign bus_io.mem_addr     = mem_addr_q;
    assign bus_io.mem_wdata    = mem_wdata_q;
    assign bus_io.disp_valid   = disp_valid_q;
    assign bus_io.disp_data    = disp_data_q;
    assign bus_io.wr_ready     = wr_ready_q;
    assign bus_io.front_bank   = front_bank_q;
    assign bus_io.swap_pending = (state_q == StWaitVs);
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Randomized and directed bench for frame_buffer_arbiter against a queue-based reference.
module tb_frame_buffer_arbiter;
    localparam int unsigned ADDR_W      = 17;
    localparam int unsigned DATA_W      = 12;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned MEM_LATENCY = 1;
    localparam int unsigned MemWords    = 1 << (ADDR_W + 1);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pix_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    frame_buffer_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    frame_buffer_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MEM_LATENCY(MEM_LATENCY)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus_io(bus)
    );

    // Behavioural BRAM
    logic [DATA_W-1:0] bram     [MemWords];
    logic [DATA_W-1:0] rd_stage [MEM_LATENCY];
    assign bus.mem_rdata = rd_stage[MEM_LATENCY-1];

    always @(posedge clk_i) begin
        for (int k = 1; k < int'(MEM_LATENCY); k++) rd_stage[k] <= rd_stage[k-1];
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            else            rd_stage[0]        <= bram[bus.mem_addr];
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [MemWords];
    pix_t fifo_m[$];
    rd_t  rdq[$];
    pix_t wq[$];
    int   cyc = 0;
    bit   model_ok = 1'b0;
    logic e_en, e_we, e_ready, e_front, e_wait, e_dvalid;
    logic [ADDR_W:0]   e_addr;
    logic [DATA_W-1:0] e_wdata, e_ddata;

    int checks = 0;
    int failures = 0;
    int n_we = 0;
    int n_acc = 0;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        return DATA_W'(a * 37 + (a >> 12) + 11);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int   n0;
        pix_t px;
        rd_t  r;
        n0 = fifo_m.size();
        if (!rst_ni) begin
            fifo_m.delete();
            rdq.delete();
            e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_ready = 0;
            e_front = 0; e_wait = 0; e_ddata = '0;
        end else begin
            if (bus.disp_req) begin
                e_en   = 1'b1;
                e_we   = 1'b0;
                e_addr = {e_front, bus.disp_addr};
                r.due  = cyc + 2 + int'(MEM_LATENCY);
                r.data = ref_mem[e_addr];
                rdq.push_back(r);
            end else if (n0 > 0) begin
                px      = fifo_m.pop_front();
                e_en    = 1'b1;
                e_we    = 1'b1;
                e_addr  = {~e_front, px.addr};
                e_wdata = px.data;
                ref_mem[e_addr] = px.data;
            end else begin
                e_en = 1'b0;
                e_we = 1'b0;
            end
            if (bus.wr_valid && e_ready) begin
                px.addr = bus.wr_addr;
                px.data = bus.wr_data;
                fifo_m.push_back(px);
            end
            if (!e_wait) begin
                if (bus.wr_frame_done) e_wait = 1'b1;
            end else if (bus.vsync_start && n0 == 0) begin
                e_wait  = 1'b0;
                e_front = ~e_front;
            end
            e_ready = (fifo_m.size() < int'(FIFO_DEPTH)) && !e_wait;
        end
        cyc++;
        e_dvalid = 1'b0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            r        = rdq.pop_front();
            e_dvalid = 1'b1;
            e_ddata  = r.data;
        end
    endtask

    task automatic check_outputs();
        check_eq("mem_en",       32'(bus.mem_en),       32'(e_en));
        check_eq("mem_we",       32'(bus.mem_we),       32'(e_we));
        check_eq("mem_addr",     32'(bus.mem_addr),     32'(e_addr));
        check_eq("mem_wdata",    32'(bus.mem_wdata),    32'(e_wdata));
        check_eq("wr_ready",     32'(bus.wr_ready),     32'(e_ready));
        check_eq("front_bank",   32'(bus.front_bank),   32'(e_front));
        check_eq("swap_pending", 32'(bus.swap_pending), 32'(e_wait));
        check_eq("disp_valid",   32'(bus.disp_valid),   32'(e_dvalid));
        check_eq("disp_data",    32'(bus.disp_data),    32'(e_ddata));
    endtask

    task automatic cycle();
        @(negedge clk_i);
        if (model_ok) check_outputs();
        @(posedge clk_i);
        model_step();
        model_ok = 1'b1;
        #1;
    endtask

    // Tracks pushes and the order in which writes reach the BRAM, then advances one cycle.
    task automatic tick();
        pix_t px;
        if (bus.mem_we) begin
            n_we++;
            if (wq.size() > 0) begin
                px = wq.pop_front();
                check_eq("wr_order_addr", 32'(bus.mem_addr[ADDR_W-1:0]), 32'(px.addr));
                check_eq("wr_order_data", 32'(bus.mem_wdata), 32'(px.data));
            end else begin
                check_eq("wr_unrequested", 32'(bus.mem_we), 32'(0));
            end
        end
        if (bus.wr_valid && bus.wr_ready) begin
            n_acc++;
            px.addr = bus.wr_addr;
            px.data = bus.wr_data;
            wq.push_back(px);
        end
        cycle();
    endtask

    task automatic idle_inputs();
        bus.disp_req      = 1'b0;
        bus.disp_addr     = '0;
        bus.wr_valid      = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.wr_frame_done = 1'b0;
        bus.vsync_start   = 1'b0;
    endtask

    task automatic rand_pixel();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_W'($urandom_range(0, 76799));
        bus.wr_data  = DATA_W'($urandom);
    endtask

    initial begin
        int acc0, we0, n_ready, p;
        for (int a = 0; a < int'(MemWords); a++) begin
            bram[a]    <= init_word(a);
            ref_mem[a] =  init_word(a);
        end
        bram[5]    <= 12'hABC;
        ref_mem[5] =  12'hABC;
        idle_inputs();

        // Reset and idle
        rst_ni = 1'b0;
        repeat (3) tick();
        check_eq("rst_ready_low", 32'(bus.wr_ready), 32'(0));
        check_eq("rst_mem_en", 32'(bus.mem_en), 32'(0));
        rst_ni = 1'b1;
        tick();
        check_eq("rel_ready", 32'(bus.wr_ready), 32'(1));
        check_eq("rel_front", 32'(bus.front_bank), 32'(0));
        repeat (3) tick();

        // Read latency
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'd5;
        tick();
        check_eq("lat_en", 32'(bus.mem_en), 32'(1));
        check_eq("lat_we", 32'(bus.mem_we), 32'(0));
        check_eq("lat_addr", 32'(bus.mem_addr), 32'h00005);
        bus.disp_req = 1'b0;
        tick();
        tick();
        check_eq("lat_valid", 32'(bus.disp_valid), 32'(1));
        check_eq("lat_data", 32'(bus.disp_data), 32'hABC);
        repeat (3) tick();

        // Priority and backpressure
        acc0 = n_acc;
        we0  = n_we;
        for (int i = 0; i < 20; i++) begin
            bus.disp_req  = 1'b1;
            bus.disp_addr = ADDR_W'($urandom_range(0, 76799));
            rand_pixel();
            tick();
        end
        check_eq("bp_accepted", 32'(n_acc - acc0), 32'(4));
        check_eq("bp_no_write", 32'(n_we - we0), 32'(0));
        check_eq("bp_ready_low", 32'(bus.wr_ready), 32'(0));
        idle_inputs();
        we0 = n_we;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_we) check_eq("bp_bank", 32'(bus.mem_addr[ADDR_W]), 32'(1));
            tick();
        end
        check_eq("bp_drain_writes", 32'(n_we - we0), 32'(4));

        // Simultaneous push and pop across pointer wrap
        bus.disp_req = 1'b1;
        rand_pixel(); tick();
        rand_pixel(); tick();
        bus.disp_req = 1'b0;
        n_ready = 0;
        for (int i = 0; i < 10; i++) begin
            rand_pixel();
            if (bus.wr_ready) n_ready++;
            tick();
        end
        check_eq("pp_ready", 32'(n_ready), 32'(10));
        idle_inputs();
        repeat (5) tick();
        check_eq("pp_drained", 32'(wq.size()), 32'(0));

        // Swap with drain
        bus.disp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pixel();
            bus.wr_frame_done = (i == 2);
            tick();
        end
        idle_inputs();
        bus.disp_req = 1'b1;
        tick();
        tick();
        check_eq("sw_pending", 32'(bus.swap_pending), 32'(1));
        bus.disp_req = 1'b0;
        tick();
        tick();
        bus.disp_req    = 1'b1;
        bus.vsync_start = 1'b1;
        tick();
        bus.vsync_start = 1'b0;
        tick();
        check_eq("sw_early_vs_pending", 32'(bus.swap_pending), 32'(1));
        check_eq("sw_early_vs_front", 32'(bus.front_bank), 32'(0));
        bus.disp_req = 1'b0;
        repeat (3) tick();
        bus.vsync_start = 1'b1;
        tick();
        bus.vsync_start = 1'b0;
        check_eq("sw_front", 32'(bus.front_bank), 32'(1));
        check_eq("sw_pending_clr", 32'(bus.swap_pending), 32'(0));
        bus.disp_req  = 1'b1;
        bus.disp_addr = ADDR_W'($urandom_range(0, 76799));
        tick();
        check_eq("sw_read_bank", 32'(bus.mem_addr[ADDR_W]), 32'(1));
        idle_inputs();
        repeat (2) tick();

        // Reset during WAIT_VS with pixels queued
        bus.disp_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_pixel();
            bus.wr_frame_done = (i == 1);
            tick();
        end
        idle_inputs();
        bus.disp_req = 1'b1;
        tick();
        check_eq("mr_pending", 32'(bus.swap_pending), 32'(1));
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        wq.delete();
        rst_ni = 1'b1;
        we0 = n_we;
        repeat (6) tick();
        check_eq("mr_no_write", 32'(n_we - we0), 32'(0));
        check_eq("mr_pending_clr", 32'(bus.swap_pending), 32'(0));
        check_eq("mr_front", 32'(bus.front_bank), 32'(0));
        check_eq("mr_ready", 32'(bus.wr_ready), 32'(1));

        // Randomized traffic with varying display load
        for (int i = 0; i < 800; i++) begin
            p = 25 * (i / 200) + 20;
            idle_inputs();
            bus.disp_req  = ($urandom_range(0, 99) < p);
            bus.disp_addr = ADDR_W'($urandom_range(0, 76799));
            if ($urandom_range(0, 9) < 7) rand_pixel();
            bus.wr_frame_done = ($urandom_range(0, 29) == 0);
            bus.vsync_start   = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        check_eq("end_drained", 32'(wq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
